// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_BLANK = 4'hF;
    localparam int DIGITS_DEF = 4;

    function automatic int max_val(input int digits);
        int r;
        r = 1;
        for (int i = 0; i < digits; i++) r = r * 10;
        return r - 1;
    endfunction

    localparam int MAX_VAL = max_val(DIGITS_DEF);

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    bcd_digit_t d;

    assign d   = d_i;
    assign d_o = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one bit per clock, start/busy/done.
// Optional leading-zero blanking with BCD_LEADING_BLANK_EN.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [31:0] MAXV = 32'(max_val(DIGITS));
    localparam logic [SW-1:0] SAT = {DIGITS{4'h9}};

    state_t          state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [SW-1:0]   scr_q, scr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic [SW-1:0]   bcd_q, bcd_d;
    logic [SW-1:0]   adj;
    logic [SW-1:0]   fmt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i(scr_q[4*g +: 4]),
            .d_o(adj[4*g +: 4])
        );
    end

    always_comb begin
        fmt = scr_q;
`ifdef BCD_LEADING_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            // Walk down from the top digit; unidades is never blanked.
            for (int i = DIGITS - 1; i > 0; i--) begin
                lead = lead && (scr_q[4*i +: 4] == 4'd0);
                if (lead) fmt[4*i +: 4] = BCD_BLANK;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    bin_d   = bin_in;
                    scr_d   = '0;
                    cnt_d   = CW'(BIN_W);
                    pend_d  = 32'(bin_in) > MAXV;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    {scr_d, bin_d} = {adj, bin_q} << 1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    ovf_d   = pend_q;
                    bcd_d   = pend_q ? SAT : fmt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd_out  = bcd_q;

endmodule
